mura_stim_gen: RTL
==================

# mura_stim_gen

Command-driven stimulus generator and checker for the three-state Moore pulse counter (mod-3 counter of `a` pulses, gated by `en`, registered flag `y` = residue ≠ 0).
On each accepted command it emits a programmed number of `a` pulses with `en`, inserting a programmable gap between pulses.
It keeps its own mod-3 model of the counter and compares the counter's `y` against that model after every pulse.
It sits beside the counter in the automaton test harness and is the driving end of the counter's `en`/`a` interface.

## Interface
- `CNT_W`, 8, width of the pulse-count field
- `GAP_W`, 4, width of the inter-pulse gap field

- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  command strobe; sampled only in IDLE
- `pulses`  in  CNT_W  number of `a` pulses to emit; latched on accept
- `gap`  in  GAP_W  idle cycles between consecutive pulses; latched on accept
- `gap_en`  in  1  drive `en`=1, `a`=0 during gap cycles (hold test); latched on accept
- `y_in`  in  1  `y` output of the counter under test
- `en`  out  1  step enable to the counter
- `a`  out  1  input pulse to the counter
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle completion pulse
- `residue`  out  2  model residue, 0..2
- `exp_y`  out  1  expected `y`, equal to (`residue` ≠ 0)
- `mismatch`  out  1  sticky compare-failure flag

## Operation
- The FSM has five states: IDLE, DRIVE, CHECK, GAP and DONE.
- `en`, `a`, `busy` and `done` are decoded from the state register and latched mode bits only. They are never combinational from inputs.
- **IDLE**
  - Outputs: `busy`=0, `en`=0, `a`=0.
  - On `start`=1: latch `pulses`, `gap` and `gap_en`, and clear `mismatch`.
  - If `pulses`=0, go to DONE; otherwise load the remaining counter with `pulses` and go to DRIVE.
- **DRIVE**
  - Outputs: `en`=1, `a`=1, `busy`=1, for exactly one cycle.
  - At the exit edge: `residue` ← (`residue`+1) mod 3, remaining ← remaining−1, go to CHECK.
- **CHECK**
  - Outputs: `en`=0, `a`=0, `busy`=1.
  - Compare `y_in` with `exp_y`; on inequality set `mismatch` at the exit edge.
  - If remaining=0, go to DONE.
  - Else, if latched gap=0, go to DRIVE; otherwise load the gap counter and go to GAP.
- **GAP**
  - Outputs: `en`=latched `gap_en`, `a`=0, `busy`=1.
  - Stays for exactly `gap` cycles, then goes to DRIVE.
- **DONE**
  - Outputs: `done`=1, `busy`=1, for one cycle, then go to IDLE.
- **`residue` lifetime**
  - `residue` persists across commands. It tracks the counter, which is cleared only by `rst_n`.
  - `residue` never takes the value 3. It wraps 2→0.
- **`mismatch` lifetime**
  - Set only in CHECK.
  - Cleared only by an accepted `start` or by reset.
- `start` outside IDLE is ignored. Inputs `pulses`, `gap` and `gap_en` may change freely after accept.
- An unused state encoding returns to IDLE.

## Timing
- **Reset values**
  - `rst_n`=0 forces, immediately and asynchronously: state IDLE, `en`=`a`=`busy`=`done`=`mismatch`=0, `residue`=0, `exp_y`=0.
  - Reset mid-command aborts it with no `done`.
- **Command timing**
  - Let `start` be accepted at edge T0.
  - The first DRIVE cycle is T0+1.
  - For N≥1 pulses with gap g: the command spans 2N+(N−1)g cycles, and `done` is high in cycle T0+2N+(N−1)g+1.
  - For N=0: `done` is high in cycle T0+1, and no `en`/`a` pulse is emitted.
- **Check latency**
  - The counter samples `en`/`a` at the DRIVE exit edge, and its `y` is valid during the next cycle.
  - CHECK therefore samples `y_in` exactly one cycle after the pulse.
- **Earliest next command**
  - The earliest next accept is the edge ending the first IDLE cycle after DONE.
  - Minimum spacing between the DONE cycle and the next DRIVE cycle is 2 cycles.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, release → all outputs 0, `residue`=0; asserting `rst_n`=0 mid-DRIVE drops `en` before the next edge.
- **Single pulse:** `start` with `pulses`=1, `gap`=0, counter attached → `en`=`a`=1 in T0+1, `done` in T0+3, `residue`=1, `exp_y`=1, `mismatch`=0.
- **Wrap with hold:**
  - Stimulus: `pulses`=3, `gap`=2, `gap_en`=1, counter attached.
  - Required: `residue` 1→2→0; `y_in` sampled 1,1,0; `en`=1/`a`=0 during gaps, with the counter holding; `done` in T0+11; `mismatch`=0.
- **Zero count:** `pulses`=0 → no `en` pulse, `done` in T0+1, `residue` unchanged.
- **Fault detection:**
  - Stimulus: `y_in` tied 0, `pulses`=2, `gap`=0.
  - Required: `mismatch` rises after the first CHECK and stays 1 through `done`; the next accepted `start` clears it.
- **Busy/persistence:**
  - Stimulus: `start` pulsed while `busy`=1; then two back-to-back commands of 2 pulses each.
  - Required: the busy-time `start` is ignored, with no change to the latched count; the second command starts from `residue`=2 and ends at `residue`=1, with `mismatch`=0.

Source files
------------

// File: rtl/mura_stim_gen_if.sv
// rtl/mura_stim_gen_if.sv - command and counter-drive bundle of the mod-3 pulse stimulus generator
interface mura_stim_gen_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] pulses;
  logic [GAP_W-1:0] gap;
  logic             gap_en;
  logic             y_in;
  logic             en;
  logic             a;
  logic             busy;
  logic             done;
  logic [1:0]       residue;
  logic             exp_y;
  logic             mismatch;

  modport master (
    input  start, pulses, gap, gap_en, y_in,
    output en, a, busy, done, residue, exp_y, mismatch
  );

  modport slave (
    output start, pulses, gap, gap_en, y_in,
    input  en, a, busy, done, residue, exp_y, mismatch
  );
endinterface

// File: rtl/mura_stim_gen.sv
// rtl/mura_stim_gen.sv - pulse stimulus generator and mod-3 checker for the Moore pulse counter
module mura_stim_gen #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mura_stim_gen_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_CHECK = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt;
  logic             gap_en_q;
  logic [1:0]       residue_q;
  logic             mismatch_q;
  logic             exp_y_w;

  assign exp_y_w = (residue_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = (bus.pulses == '0) ? S_DONE : S_DRIVE;
        else           state_nxt = S_IDLE;
      end
      S_DRIVE: state_nxt = S_CHECK;
      // rem was already decremented on the DRIVE exit edge
      S_CHECK: begin
        if (rem == '0)        state_nxt = S_DONE;
        else if (gap_q == '0) state_nxt = S_DRIVE;
        else                  state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = (gcnt == GAP_W'(1)) ? S_DRIVE : S_GAP;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= '0;
      gap_q      <= '0;
      gcnt       <= '0;
      gap_en_q   <= 1'b0;
      residue_q  <= 2'd0;
      mismatch_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rem        <= bus.pulses;
            gap_q      <= bus.gap;
            gap_en_q   <= bus.gap_en;
            mismatch_q <= 1'b0;
          end
        end
        S_DRIVE: begin
          residue_q <= (residue_q == 2'd2) ? 2'd0 : residue_q + 2'd1;
          rem       <= rem - CNT_W'(1);
        end
        S_CHECK: begin
          if (bus.y_in != exp_y_w) mismatch_q <= 1'b1;
          gcnt <= gap_q;
        end
        S_GAP:   gcnt <= gcnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs depend only on the state register and latched mode bits
  assign bus.en       = (state == S_DRIVE) || ((state == S_GAP) && gap_en_q);
  assign bus.a        = (state == S_DRIVE);
  assign bus.busy     = (state == S_DRIVE) || (state == S_CHECK) ||
                        (state == S_GAP)   || (state == S_DONE);
  assign bus.done     = (state == S_DONE);
  assign bus.residue  = residue_q;
  assign bus.exp_y    = exp_y_w;
  assign bus.mismatch = mismatch_q;

endmodule
